regfile_wr_arbiter: RTL and testbench

- Shares the register file's single write port (5-bit address, 4-bit byte-enable, 32-bit data) between two writers.
- Writer A is the pipeline WB stage. It has priority, no ready signal, and a stall-only backpressure path.
- Writer B is the multi-cycle mul/div unit. It uses a valid/ready handshake and is buffered in a small FIFO.
- Also exports a per-register busy vector so decode can stall on registers with outstanding B writes.

---
 rtl/regfile_wr_arbiter_pkg.sv | 18 +
 rtl/regfile_wr_fifo.sv | 114 +++++++++++
 rtl/regfile_wr_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  localparam logic [3:0] WEN_FULL = 4'hF;
  localparam logic [3:0] WEN_NONE = 4'h0;

  // One queued mul/div result. live=0 means the slot still drains but
  // must not modify the register file (r0 target or squashed by WB).
  typedef struct packed {
    logic                  live;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } rf_entry_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Small circular buffer holding mul/div results waiting for the write port.
// Every slot is a plain register so the WAW squash can clear all matching
// live bits in one edge and the busy vector can see every entry at once.
module regfile_wr_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  rf_entry_t                   push_entry_i,
  input  logic                        pop_i,
  input  logic                        squash_en_i,
  input  logic [ADDR_WIDTH-1:0]       squash_addr_i,
  output logic                        full_o,
  output logic                        empty_o,
  output rf_entry_t                   head_o,
  output logic [DEPTH-1:0]            occ_o,
  output logic [DEPTH-1:0]            live_o,
  output logic [DEPTH*ADDR_WIDTH-1:0] addr_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;
  rf_entry_t        slot_view [DEPTH];

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = slot_view[rd_ptr_q];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    rf_entry_t slot_q;
    logic      occ_q;
    logic      wr_hit;
    logic      rd_hit;
    logic      sq_hit;

    // A slot cannot be written and read in the same edge: that would need
    // the buffer to be both full (for the read) and not full (for the write).
    assign wr_hit = push_ok && (wr_ptr_q == PTR_W'(gi));
    assign rd_hit = pop_ok && (rd_ptr_q == PTR_W'(gi));
    assign sq_hit = squash_en_i && occ_q && (slot_q.addr == squash_addr_i);

    // Slot contents: a fresh push wins over a squash, so a same-cycle push
    // to the squashed address stays live.
    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
        slot_q <= '0;
      end else if (wr_hit) begin
        slot_q <= push_entry_i;
      end else if (sq_hit) begin
        slot_q.live <= 1'b0;
      end
    end

    // Slot occupancy, used to qualify the busy contribution of this slot.
    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
        occ_q <= 1'b0;
      end else if (wr_hit) begin
        occ_q <= 1'b1;
      end else if (rd_hit) begin
        occ_q <= 1'b0;
      end
    end

    assign slot_view[gi]                        = slot_q;
    assign occ_o[gi]                            = occ_q;
    assign live_o[gi]                           = slot_q.live;
    assign addr_o[gi*ADDR_WIDTH +: ADDR_WIDTH]  = slot_q.addr;
  end

  // Next pointers and occupancy; DEPTH is a power of two so the pointers
  // wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port between the WB stage
// (priority, stall-only) and the mul/div unit (valid/ready, FIFO-buffered).
// A starvation counter forces the FIFO head through after STARVE_LIMIT
// cycles of waiting, and a busy vector flags registers with pending B writes.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = regfile_wr_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = regfile_wr_arbiter_pkg::DATA_WIDTH,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [ADDR_WIDTH-1:0]      wb_addr,
  input  logic [3:0]                 wb_wen,
  input  logic [DATA_WIDTH-1:0]      wb_data,
  output logic                       wb_stall,
  input  logic                       md_valid,
  output logic                       md_ready,
  input  logic [ADDR_WIDTH-1:0]      md_addr,
  input  logic [DATA_WIDTH-1:0]      md_data,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [3:0]                 rf_wen,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [(1<<ADDR_WIDTH)-1:0] busy
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic                        active_q;
  logic [SC_W-1:0]             starve_q, starve_d;
  logic                        wb_eff;
  logic                        force_drain;
  logic                        pass_thru;
  logic                        pop;
  logic                        push;
  rf_entry_t                   push_entry;
  rf_entry_t                   head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [DEPTH-1:0]            slot_occ;
  logic [DEPTH-1:0]            slot_live;
  logic [DEPTH*ADDR_WIDTH-1:0] slot_addr;

  // WB writes to r0 or with no byte lanes are no-ops; the reset term keeps
  // the combinational pass-through quiet while reset is asserted.
  assign wb_eff      = rst && wb_valid && (wb_wen != WEN_NONE) && (wb_addr != '0);
  assign force_drain = !fifo_empty && (starve_q == SC_W'(STARVE_LIMIT));
  assign pass_thru   = wb_eff && !force_drain;
  assign pop         = !fifo_empty && !pass_thru;
  assign wb_stall    = force_drain;

  // Ready only depends on fullness (a full FIFO never accepts, even while
  // draining); active_q holds it low until the first edge after reset.
  assign md_ready    = active_q && !fifo_full;
  assign push        = md_valid && md_ready;
  assign push_entry  = '{live: (md_addr != '0), addr: md_addr, data: md_data};

  regfile_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_ni        (rst),
    .push_i        (push),
    .push_entry_i  (push_entry),
    .pop_i         (pop),
    .squash_en_i   (pass_thru),
    .squash_addr_i (wb_addr),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .head_o        (head),
    .occ_o         (slot_occ),
    .live_o        (slot_live),
    .addr_o        (slot_addr)
  );

  // Enables md_ready from the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  // Starvation count: cleared whenever the head moves or nothing waits,
  // otherwise counts waiting cycles up to the limit.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != SC_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Write-port mux: WB pass-through, else FIFO head, else idle zeros.
  always_comb begin
    rf_waddr = '0;
    rf_wen   = WEN_NONE;
    rf_wdata = '0;
    if (pass_thru) begin
      rf_waddr = wb_addr;
      rf_wen   = wb_wen;
      rf_wdata = wb_data;
    end else if (!fifo_empty) begin
      rf_waddr = head.addr;
      rf_wen   = head.live ? WEN_FULL : WEN_NONE;
      rf_wdata = head.data;
    end
  end

  // Busy vector: r0 is never busy since writes to it are discarded.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign busy[gi] = 1'b0;
    end else begin : g_reg
      logic hit;
      // OR of live, occupied slots that target this register.
      always_comb begin
        hit = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
          hit = hit | (slot_occ[e] & slot_live[e] &
                       (slot_addr[e*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(gi)));
        end
      end
      assign busy[gi] = hit;
    end
  end

  // A stalled WB request must still be presented on the following cycle.
  a_wb_hold: assert property (@(posedge clk) disable iff (!rst)
                              (wb_stall && wb_valid) |=> wb_valid);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, state advances on the rising edge.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [3:0]  wb_wen;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [4:0]  rf_waddr;
  logic [3:0]  rf_wen;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(
    .ADDR_WIDTH   (5),
    .DATA_WIDTH   (32),
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_wen   (wb_wen),
    .wb_data  (wb_data),
    .wb_stall (wb_stall),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .md_addr  (md_addr),
    .md_data  (md_data),
    .rf_waddr (rf_waddr),
    .rf_wen   (rf_wen),
    .rf_wdata (rf_wdata),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rf(input string tag, input logic [4:0] a, input logic [3:0] w,
                          input logic [31:0] d);
    check({tag, ".waddr"}, 64'(rf_waddr), 64'(a));
    check({tag, ".wen"},   64'(rf_wen),   64'(w));
    check({tag, ".wdata"}, 64'(rf_wdata), 64'(d));
    $display("%0t %s: rf waddr=%0d wen=%h wdata=%h busy=%h stall=%b ready=%b",
             $time, tag, rf_waddr, rf_wen, rf_wdata, busy, wb_stall, md_ready);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_addr = '0; wb_wen = '0; wb_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [3:0] w, input logic [31:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_wen = w; wb_data = d;
  endtask

  task automatic wb_off();
    wb_valid = 1'b0; wb_addr = '0; wb_wen = '0; wb_data = '0;
  endtask

  task automatic md(input logic [4:0] a, input logic [31:0] d);
    md_valid = 1'b1; md_addr = a; md_data = d;
  endtask

  task automatic md_off();
    md_valid = 1'b0; md_addr = '0; md_data = '0;
  endtask

  initial begin
    // Reset held with both requesters active.
    rst = 1'b0;
    idle();
    wb(5'd3, 4'hF, 32'h1234);
    md(5'd4, 32'h1);
    cyc();
    #1;
    check_rf("reset", 5'd0, 4'h0, 32'h0);
    check("reset.md_ready", 64'(md_ready), 64'd0);
    check("reset.busy",     64'(busy),     64'd0);
    check("reset.wb_stall", 64'(wb_stall), 64'd0);
    idle();
    rst = 1'b1;
    #1;
    check("release.md_ready", 64'(md_ready), 64'd0);
    cyc();
    #1;
    check("release.md_ready_next", 64'(md_ready), 64'd1);
    check_rf("idle", 5'd0, 4'h0, 32'h0);

    // B-only write to r5.
    md(5'd5, 32'hDEADBEEF);
    #1;
    check("bonly.ready", 64'(md_ready), 64'd1);
    check_rf("bonly.t", 5'd0, 4'h0, 32'h0);
    cyc();
    md_off();
    #1;
    check("bonly.busy_t1", 64'(busy), 64'h20);
    check_rf("bonly.t1", 5'd5, 4'hF, 32'hDEADBEEF);
    cyc();
    #1;
    check("bonly.busy_t2", 64'(busy), 64'h0);
    check("bonly.wen_t2",  64'(rf_wen), 64'h0);

    // Priority then starvation: r7 waits through four WB writes.
    md(5'd7, 32'h77);
    cyc();
    md_off();
    for (int i = 0; i < 4; i++) begin
      wb(5'(10 + i), 4'hF, 32'hA0 + 32'(i));
      #1;
      check("starve.stall", 64'(wb_stall), 64'd0);
      check_rf("starve.pass", 5'(10 + i), 4'hF, 32'hA0 + 32'(i));
      cyc();
    end
    wb(5'd14, 4'hF, 32'hA4);
    #1;
    check("starve.force_stall", 64'(wb_stall), 64'd1);
    check_rf("starve.force", 5'd7, 4'hF, 32'h77);
    cyc();
    #1;
    check("starve.replay_stall", 64'(wb_stall), 64'd0);
    check_rf("starve.replay", 5'd14, 4'hF, 32'hA4);
    cyc();
    wb_off();

    // Full FIFO with a held third result.
    md(5'd1, 32'h101);
    wb(5'd20, 4'hF, 32'hB0);
    #1;
    check_rf("full.c1", 5'd20, 4'hF, 32'hB0);
    cyc();
    md(5'd2, 32'h202);
    wb(5'd21, 4'hF, 32'hB1);
    #1;
    check("full.c2_ready", 64'(md_ready), 64'd1);
    check_rf("full.c2", 5'd21, 4'hF, 32'hB1);
    cyc();
    md(5'd3, 32'h303);
    wb(5'd22, 4'hF, 32'hB2);
    #1;
    check("full.c3_ready", 64'(md_ready), 64'd0);
    check("full.c3_busy",  64'(busy),     64'h6);
    check_rf("full.c3", 5'd22, 4'hF, 32'hB2);
    cyc();
    wb_off();
    #1;
    check("full.c4_ready", 64'(md_ready), 64'd0);
    check("full.c4_stall", 64'(wb_stall), 64'd0);
    check_rf("full.c4", 5'd1, 4'hF, 32'h101);
    cyc();
    #1;
    check("full.c5_ready", 64'(md_ready), 64'd1);
    check_rf("full.c5", 5'd2, 4'hF, 32'h202);
    cyc();
    md_off();
    #1;
    check("full.c6_busy", 64'(busy), 64'h8);
    check_rf("full.c6", 5'd3, 4'hF, 32'h303);
    cyc();
    #1;
    check("full.c7_busy", 64'(busy), 64'h0);
    check("full.c7_wen",  64'(rf_wen), 64'h0);

    // WAW squash of a queued r9 by a WB write.
    md(5'd9, 32'h11);
    cyc();
    md_off();
    wb(5'd9, 4'h3, 32'h22);
    #1;
    check("waw.busy_pre", 64'(busy), 64'h200);
    check_rf("waw.wb", 5'd9, 4'h3, 32'h22);
    cyc();
    wb_off();
    #1;
    check("waw.busy_post", 64'(busy), 64'h0);
    check_rf("waw.drain", 5'd9, 4'h0, 32'h11);
    cyc();
    // Same-cycle push to the WB address stays live.
    md(5'd9, 32'h33);
    wb(5'd9, 4'hF, 32'h44);
    #1;
    check_rf("waw.same_wb", 5'd9, 4'hF, 32'h44);
    cyc();
    idle();
    #1;
    check("waw.same_busy", 64'(busy), 64'h200);
    check_rf("waw.same_drain", 5'd9, 4'hF, 32'h33);
    cyc();

    // No-op WB requests and a push to r0.
    md(5'd0, 32'h55);
    #1;
    check("noop.ready", 64'(md_ready), 64'd1);
    cyc();
    md_off();
    wb(5'd0, 4'hF, 32'h99);
    #1;
    check("noop.r0_busy",  64'(busy),     64'h0);
    check("noop.r0_stall", 64'(wb_stall), 64'd0);
    check_rf("noop.r0_drain", 5'd0, 4'h0, 32'h55);
    cyc();
    idle();
    md(5'd6, 32'h66);
    cyc();
    md_off();
    wb(5'd4, 4'h0, 32'h99);
    #1;
    check_rf("noop.wen0", 5'd6, 4'hF, 32'h66);
    cyc();
    idle();
    #1;
    check_rf("noop.idle", 5'd0, 4'h0, 32'h0);

    // Reset mid-operation discards a queued entry.
    md(5'd11, 32'hAB);
    cyc();
    md_off();
    #1;
    check("midrst.busy_pre", 64'(busy), 64'h800);
    #2;
    rst = 1'b0;
    #1;
    check("midrst.busy",  64'(busy),     64'h0);
    check("midrst.ready", 64'(md_ready), 64'd0);
    check("midrst.wen",   64'(rf_wen),   64'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    #1;
    check("midrst.after_wen",   64'(rf_wen),   64'h0);
    check("midrst.after_busy",  64'(busy),     64'h0);
    check("midrst.after_ready", 64'(md_ready), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
